// File: rtl/cpu6_memstage_pkg.sv
// cpu6 MEM-stage shared definitions: LSU access sizes and MEM-stage FSM state encodings.
package cpu6_memstage_pkg;

  localparam int unsigned CPU6_LSU_SIZE_WIDTH = 2;

  localparam logic [CPU6_LSU_SIZE_WIDTH-1:0] CPU6_LSU_SIZE_B = 2'b00;
  localparam logic [CPU6_LSU_SIZE_WIDTH-1:0] CPU6_LSU_SIZE_H = 2'b01;
  localparam logic [CPU6_LSU_SIZE_WIDTH-1:0] CPU6_LSU_SIZE_W = 2'b10;

  localparam logic CPU6_MEMST_IDLE = 1'b0;
  localparam logic CPU6_MEMST_WAIT = 1'b1;

  typedef enum logic {
    MEMST_IDLE = CPU6_MEMST_IDLE,
    MEMST_WAIT = CPU6_MEMST_WAIT
  } memst_state_e;

  // Width of the wait-state counter; covers TIMEOUT up to 255.
  localparam int unsigned CPU6_MEMST_CNT_WIDTH = 8;

endpackage

// File: rtl/cpu6_lsu_align.sv
// Load/store lane alignment: byte enables, store-data replication, load lane
// extract with sign/zero extension, and misalignment detection.
// Ports:
//   size        access size (B/H/W; 11 treated as word)
//   zero_ext    zero-extend loads instead of sign-extending
//   offset      byte offset within the word (addr[1:0])
//   store_data  store data from the register file
//   rdata       raw read word from data memory
//   be          byte enables
//   wdata       lane-replicated store data
//   load_data   extracted, extended load value
//   misalign    access violates natural alignment
module cpu6_lsu_align
  import cpu6_memstage_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [CPU6_LSU_SIZE_WIDTH-1:0] size,
  input  logic                           zero_ext,
  input  logic [1:0]                     offset,
  input  logic [XLEN-1:0]                store_data,
  input  logic [XLEN-1:0]                rdata,
  output logic [XLEN/8-1:0]              be,
  output logic [XLEN-1:0]                wdata,
  output logic [XLEN-1:0]                load_data,
  output logic                           misalign
);

  localparam int unsigned NB = XLEN / 8;

  logic [XLEN-1:0] lane;

  // Shift the addressed lane down to bit 0, then size and extend it.
  always_comb begin
    lane      = rdata >> {offset, 3'b000};
    be        = '1;
    wdata     = store_data;
    load_data = lane;
    misalign  = 1'b0;
    case (size)
      CPU6_LSU_SIZE_B: begin
        be        = NB'(1) << offset;
        wdata     = {4{store_data[7:0]}};
        load_data = zero_ext ? XLEN'(lane[7:0]) : {{(XLEN-8){lane[7]}}, lane[7:0]};
      end
      CPU6_LSU_SIZE_H: begin
        misalign  = offset[0];
        be        = NB'(3) << offset;
        wdata     = {2{store_data[15:0]}};
        load_data = zero_ext ? XLEN'(lane[15:0]) : {{(XLEN-16){lane[15]}}, lane[15:0]};
      end
      default: begin
        misalign  = (offset != 2'b00);
      end
    endcase
  end

endmodule

// File: rtl/cpu6_memstage.sv
// cpu6 MEM stage: EX/MEM register, load/store unit with wait-state handshake
// and bus timeout, writeback select, MEM-stage forwarding source, MEM/WB register.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   validE..csr_rdatE          EX-stage instruction and operands
//   flushM                     kill the un-issued instruction in M
//   stallM                     M is holding; upstream must freeze
//   dmem_*                     data-memory request/response
//   fwd_validM/regM/dataM      forwarding source from M
//   regwriteW/writeregW/rdW    register-file write port
//   exc_misalignM/buserrM/addrM  exception pulses and faulting address
module cpu6_memstage
  import cpu6_memstage_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned RFIDX_WIDTH = 5,
  parameter int unsigned TIMEOUT     = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           validE,
  input  logic                           memwriteE,
  input  logic                           memtoregE,
  input  logic                           regwriteE,
  input  logic                           jumpE,
  input  logic                           csrE,
  input  logic [CPU6_LSU_SIZE_WIDTH-1:0] lsu_sizeE,
  input  logic                           lsu_unsignedE,
  input  logic [XLEN-1:0]                aluoutE,
  input  logic [XLEN-1:0]                writedataE,
  input  logic [RFIDX_WIDTH-1:0]         writeregE,
  input  logic [XLEN-1:0]                pcplus4E,
  input  logic [XLEN-1:0]                csr_rdatE,
  input  logic                           flushM,
  output logic                           stallM,
  output logic                           dmem_req,
  output logic                           dmem_we,
  output logic [XLEN-1:0]                dmem_addr,
  output logic [XLEN-1:0]                dmem_wdata,
  output logic [XLEN/8-1:0]              dmem_be,
  input  logic                           dmem_ready,
  input  logic [XLEN-1:0]                dmem_rdata,
  output logic                           fwd_validM,
  output logic [RFIDX_WIDTH-1:0]         fwd_regM,
  output logic [XLEN-1:0]                fwd_dataM,
  output logic                           regwriteW,
  output logic [RFIDX_WIDTH-1:0]         writeregW,
  output logic [XLEN-1:0]                rdW,
  output logic                           exc_misalignM,
  output logic                           exc_buserrM,
  output logic [XLEN-1:0]                exc_addrM
);

  localparam int unsigned CW = CPU6_MEMST_CNT_WIDTH;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  // EX/MEM pipeline register contents
  logic                           valid_m, memwrite_m, memtoreg_m, regwrite_m;
  logic                           jump_m, csr_m, unsigned_m;
  logic [CPU6_LSU_SIZE_WIDTH-1:0] size_m;
  logic [XLEN-1:0]                aluout_m, writedata_m, pcplus4_m, csr_rdat_m;
  logic [RFIDX_WIDTH-1:0]         writereg_m;

  memst_state_e  state;
  logic [CW-1:0] cnt;

  logic              is_mem, live, misalign, req, done, timeout, stall, fwd_v;
  logic [XLEN/8-1:0] be;
  logic [XLEN-1:0]   wdata, load_data, rd_m;

  cpu6_lsu_align #(.XLEN(XLEN)) u_align (
    .size       (size_m),
    .zero_ext   (unsigned_m),
    .offset     (aluout_m[1:0]),
    .store_data (writedata_m),
    .rdata      (dmem_rdata),
    .be         (be),
    .wdata      (wdata),
    .load_data  (load_data),
    .misalign   (misalign)
  );

  // Handshake control. A flush only kills while IDLE; once in WAIT the
  // request is committed. Ready beats timeout in the same cycle.
  always_comb begin
    is_mem  = memwrite_m | memtoreg_m;
    live    = ~reset & valid_m & ~(flushM & (state == MEMST_IDLE));
    req     = live & is_mem & ~misalign;
    done    = req & dmem_ready;
    timeout = req & ~dmem_ready & (cnt == CNT_LAST);
    stall   = req & ~dmem_ready & ~timeout;
    fwd_v   = live & regwrite_m & (is_mem ? (memtoreg_m & done) : 1'b1);
    rd_m    = aluout_m;
    if (csr_m)           rd_m = csr_rdat_m;
    else if (jump_m)     rd_m = pcplus4_m;
    else if (memtoreg_m) rd_m = load_data;
  end

  assign stallM        = stall;
  assign dmem_req      = req;
  assign dmem_we       = req & memwrite_m;
  assign dmem_addr     = req ? {aluout_m[XLEN-1:2], 2'b00} : '0;
  assign dmem_wdata    = req ? wdata : '0;
  assign dmem_be       = req ? be : '0;
  assign fwd_validM    = fwd_v;
  assign fwd_regM      = fwd_v ? writereg_m : '0;
  assign fwd_dataM     = fwd_v ? rd_m : '0;
  assign exc_misalignM = live & is_mem & misalign;
  assign exc_buserrM   = timeout;
  assign exc_addrM     = (exc_misalignM | timeout) ? aluout_m : '0;

  // EX/MEM register; holds while stalled, flush inserts a bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_m     <= 1'b0;
      memwrite_m  <= 1'b0;
      memtoreg_m  <= 1'b0;
      regwrite_m  <= 1'b0;
      jump_m      <= 1'b0;
      csr_m       <= 1'b0;
      unsigned_m  <= 1'b0;
      size_m      <= '0;
      aluout_m    <= '0;
      writedata_m <= '0;
      pcplus4_m   <= '0;
      csr_rdat_m  <= '0;
      writereg_m  <= '0;
    end else if (!stall) begin
      valid_m     <= validE & ~flushM;
      memwrite_m  <= memwriteE;
      memtoreg_m  <= memtoregE;
      regwrite_m  <= regwriteE;
      jump_m      <= jumpE;
      csr_m       <= csrE;
      unsigned_m  <= lsu_unsignedE;
      size_m      <= lsu_sizeE;
      aluout_m    <= aluoutE;
      writedata_m <= writedataE;
      pcplus4_m   <= pcplus4E;
      csr_rdat_m  <= csr_rdatE;
      writereg_m  <= writeregE;
    end
  end

  // Wait-state FSM; the counter counts the issue cycle as wait cycle 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= MEMST_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        MEMST_IDLE: begin
          if (stall) begin
            state <= MEMST_WAIT;
            cnt   <= cnt + CW'(1);
          end
        end
        MEMST_WAIT: begin
          if (stall) begin
            cnt <= cnt + CW'(1);
          end else begin
            state <= MEMST_IDLE;
            cnt   <= '0;
          end
        end
        default: begin
          state <= MEMST_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // MEM/WB register; x0 writes are suppressed.
  always_ff @(posedge clk) begin
    if (reset) begin
      regwriteW <= 1'b0;
      writeregW <= '0;
      rdW       <= '0;
    end else begin
      regwriteW <= fwd_v & (writereg_m != '0);
      writeregW <= writereg_m;
      rdW       <= rd_m;
    end
  end

endmodule

// File: tb/tb_cpu6_memstage.sv
// Self-checking bench for cpu6_memstage: directed cases plus randomized
// instruction stream checked against an arithmetic reference model.
module tb_cpu6_memstage;

  localparam int unsigned XLEN = 32;
  localparam int unsigned RW   = 5;
  localparam int          TO   = 16;

  logic            clk, reset;
  logic            validE, memwriteE, memtoregE, regwriteE, jumpE, csrE;
  logic [1:0]      lsu_sizeE;
  logic            lsu_unsignedE;
  logic [XLEN-1:0] aluoutE, writedataE, pcplus4E, csr_rdatE;
  logic [RW-1:0]   writeregE;
  logic            flushM, stallM, dmem_req, dmem_we, dmem_ready;
  logic [XLEN-1:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]      dmem_be;
  logic            fwd_validM, regwriteW, exc_misalignM, exc_buserrM;
  logic [RW-1:0]   fwd_regM, writeregW;
  logic [XLEN-1:0] fwd_dataM, rdW, exc_addrM;

  cpu6_memstage #(.XLEN(XLEN), .RFIDX_WIDTH(RW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .validE(validE), .memwriteE(memwriteE),
    .memtoregE(memtoregE), .regwriteE(regwriteE), .jumpE(jumpE), .csrE(csrE),
    .lsu_sizeE(lsu_sizeE), .lsu_unsignedE(lsu_unsignedE), .aluoutE(aluoutE),
    .writedataE(writedataE), .writeregE(writeregE), .pcplus4E(pcplus4E),
    .csr_rdatE(csr_rdatE), .flushM(flushM), .stallM(stallM), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_be(dmem_be), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .fwd_validM(fwd_validM), .fwd_regM(fwd_regM), .fwd_dataM(fwd_dataM),
    .regwriteW(regwriteW), .writeregW(writeregW), .rdW(rdW),
    .exc_misalignM(exc_misalignM), .exc_buserrM(exc_buserrM), .exc_addrM(exc_addrM)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef struct {
    bit st, ld, rw, jp, cs, uns;
    logic [1:0]  size;
    logic [31:0] addr, wd, pc4, csrd, rdata;
    logic [4:0]  rd;
    int          wait_n;      // cycle index at which ready is given
    int          flush_mode;  // 0 none, 1 flush while idle, 2 flush while waiting
  } op_t;

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  function automatic int unsigned nbytes(input logic [1:0] size);
    return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit ref_misalign(input logic [1:0] size, input logic [31:0] addr);
    return (addr % nbytes(size)) != 0;
  endfunction

  function automatic logic [3:0] ref_be(input logic [1:0] size, input logic [31:0] addr);
    int unsigned n = nbytes(size);
    int unsigned b = ((1 << n) - 1) << (addr % 4);
    return 4'(b);
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [1:0] size, input logic [31:0] d);
    if (nbytes(size) == 1) return (d % 256) * 32'h0101_0101;
    if (nbytes(size) == 2) return (d % 65536) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] size, input bit uns,
                                           input logic [31:0] addr, input logic [31:0] rdata);
    longint unsigned bits = 64'(8 * nbytes(size));
    longint unsigned span = 64'd1 << bits;
    longint unsigned v = (64'(rdata) >> (8 * (addr % 4))) % span;
    if (!uns && v >= (span / 2)) v = v - span;
    return 32'(v);
  endfunction

  function automatic op_t blank();
    op_t o;
    o.st = 0; o.ld = 0; o.rw = 0; o.jp = 0; o.cs = 0; o.uns = 0;
    o.size = 2'd2; o.addr = '0; o.wd = '0; o.pc4 = '0; o.csrd = '0; o.rdata = '0;
    o.rd = '0; o.wait_n = 0; o.flush_mode = 0;
    return o;
  endfunction

  // Push one instruction through M and check it against the reference model.
  task automatic run_op(input op_t o);
    bit is_mem, flushed, mis, issued, tmo, fwd_v, writes;
    int last;
    logic [31:0] rexp;
    @(negedge clk);
    validE = 1'b1; memwriteE = o.st; memtoregE = o.ld; regwriteE = o.rw;
    jumpE = o.jp; csrE = o.cs; lsu_sizeE = o.size; lsu_unsignedE = o.uns;
    aluoutE = o.addr; writedataE = o.wd; writeregE = o.rd;
    pcplus4E = o.pc4; csr_rdatE = o.csrd;
    @(negedge clk);
    validE = 1'b0;
    is_mem  = o.st || o.ld;
    flushed = (o.flush_mode == 1);
    mis     = is_mem && !flushed && ref_misalign(o.size, o.addr);
    issued  = is_mem && !flushed && !ref_misalign(o.size, o.addr);
    tmo     = issued && (o.wait_n > TO - 1);
    last    = !issued ? 0 : (o.wait_n < TO - 1) ? o.wait_n : TO - 1;
    fwd_v   = o.rw && !flushed && !mis && !tmo && (!is_mem || o.ld);
    writes  = fwd_v && (o.rd != 0);
    rexp    = o.cs ? o.csrd : o.jp ? o.pc4 : o.ld ? ref_load(o.size, o.uns, o.addr, o.rdata) : o.addr;
    for (int k = 0; k <= last; k++) begin
      dmem_ready = issued && (k == o.wait_n);
      dmem_rdata = o.rdata;
      flushM     = (o.flush_mode == 1 && k == 0) || (o.flush_mode == 2 && k >= 1);
      #1;
      check1("stallM", stallM, issued && (k < last));
      check1("dmem_req", dmem_req, issued);
      if (issued) begin
        check32("dmem_addr", dmem_addr, o.addr & 32'hFFFF_FFFC);
        check32("dmem_be", 32'(dmem_be), 32'(ref_be(o.size, o.addr)));
        check1("dmem_we", dmem_we, o.st);
        if (o.st) check32("dmem_wdata", dmem_wdata, ref_wdata(o.size, o.wd));
      end
      check1("fwd_validM", fwd_validM, fwd_v && (k == last));
      if (k == last) begin
        check1("exc_misalignM", exc_misalignM, mis);
        check1("exc_buserrM", exc_buserrM, tmo);
        if (mis || tmo) check32("exc_addrM", exc_addrM, o.addr);
        if (fwd_v) begin
          check32("fwd_regM", 32'(fwd_regM), 32'(o.rd));
          check32("fwd_dataM", fwd_dataM, rexp);
        end
      end
      @(negedge clk);
    end
    dmem_ready = 1'b0;
    flushM     = 1'b0;
    #1;
    check1("regwriteW", regwriteW, writes);
    if (writes) begin
      check32("writeregW", 32'(writeregW), 32'(o.rd));
      check32("rdW", rdW, rexp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check1({tag, "_stallM"}, stallM, 1'b0);
    check1({tag, "_dmem_req"}, dmem_req, 1'b0);
    check1({tag, "_dmem_we"}, dmem_we, 1'b0);
    check32({tag, "_dmem_addr"}, dmem_addr, 32'h0);
    check32({tag, "_dmem_wdata"}, dmem_wdata, 32'h0);
    check32({tag, "_dmem_be"}, 32'(dmem_be), 32'h0);
    check1({tag, "_fwd_validM"}, fwd_validM, 1'b0);
    check32({tag, "_fwd_regM"}, 32'(fwd_regM), 32'h0);
    check32({tag, "_fwd_dataM"}, fwd_dataM, 32'h0);
    check1({tag, "_regwriteW"}, regwriteW, 1'b0);
    check32({tag, "_writeregW"}, 32'(writeregW), 32'h0);
    check32({tag, "_rdW"}, rdW, 32'h0);
    check1({tag, "_exc_misalignM"}, exc_misalignM, 1'b0);
    check1({tag, "_exc_buserrM"}, exc_buserrM, 1'b0);
    check32({tag, "_exc_addrM"}, exc_addrM, 32'h0);
  endtask

  initial begin
    op_t o;
    int t, r;
    reset = 1'b1; validE = 0; memwriteE = 0; memtoregE = 0; regwriteE = 0;
    jumpE = 0; csrE = 0; lsu_sizeE = '0; lsu_unsignedE = 0; aluoutE = '0;
    writedataE = '0; writeregE = '0; pcplus4E = '0; csr_rdatE = '0;
    flushM = 0; dmem_ready = 0; dmem_rdata = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check_all_zero("reset");

    // ALU result to x5
    o = blank(); o.rw = 1; o.addr = 32'h1234_5678; o.rd = 5; run_op(o);
    // lb / lbu from the top byte lane
    o = blank(); o.ld = 1; o.rw = 1; o.size = 2'd0; o.addr = 32'h103; o.rdata = 32'h80FF_0000;
    o.rd = 7; run_op(o);
    o.uns = 1; run_op(o);
    // sh with three wait cycles
    o = blank(); o.st = 1; o.size = 2'd1; o.addr = 32'h102; o.wd = 32'h0000_ABCD; o.wait_n = 3;
    run_op(o);
    // misaligned lw
    o = blank(); o.ld = 1; o.rw = 1; o.addr = 32'h101; o.rd = 9; run_op(o);
    // lw that never gets ready, then a normal instruction
    o = blank(); o.ld = 1; o.rw = 1; o.addr = 32'h200; o.rd = 10; o.wait_n = 1000; run_op(o);
    o = blank(); o.rw = 1; o.addr = 32'hCAFE_0001; o.rd = 11; run_op(o);
    // ready on the last allowed cycle beats the timeout
    o = blank(); o.ld = 1; o.rw = 1; o.addr = 32'h204; o.rd = 12; o.rdata = 32'h5A5A_1234;
    o.wait_n = TO - 1; run_op(o);
    // flush while waiting is ignored; flush while idle kills the store
    o = blank(); o.ld = 1; o.rw = 1; o.addr = 32'h300; o.rd = 13; o.rdata = 32'h0BAD_F00D;
    o.wait_n = 3; o.flush_mode = 2; run_op(o);
    o = blank(); o.st = 1; o.addr = 32'h304; o.wd = 32'h1111_2222; o.flush_mode = 1; run_op(o);
    // csr beats jump; jump link; x0 suppressed
    o = blank(); o.rw = 1; o.cs = 1; o.jp = 1; o.csrd = 32'hC5C5_0000; o.pc4 = 32'h44; o.rd = 14;
    run_op(o);
    o = blank(); o.rw = 1; o.jp = 1; o.pc4 = 32'h0000_1004; o.addr = 32'h99; o.rd = 15; run_op(o);
    o = blank(); o.rw = 1; o.addr = 32'h77; o.rd = 0; run_op(o);

    // reset asserted while waiting abandons the request
    @(negedge clk);
    validE = 1; memwriteE = 0; memtoregE = 1; regwriteE = 1; jumpE = 0; csrE = 0;
    lsu_sizeE = 2'd2; aluoutE = 32'h400; writeregE = 5'd3;
    @(negedge clk);
    validE = 0; dmem_ready = 0;
    repeat (3) @(negedge clk);
    #1;
    check1("wait_before_reset", stallM, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_all_zero("reset_in_wait");

    // randomized instruction stream
    for (int n = 0; n < 120; n++) begin
      o = blank();
      t = int'($urandom_range(0, 4));
      o.rw = (t != 4) ? 1'b1 : 1'($urandom_range(0, 1));
      o.cs = (t == 1); o.jp = (t == 2); o.ld = (t == 3); o.st = (t == 4);
      o.size = 2'($urandom_range(0, 3)); o.uns = 1'($urandom_range(0, 1));
      o.addr = $urandom; o.wd = $urandom; o.pc4 = $urandom; o.csrd = $urandom;
      o.rdata = $urandom; o.rd = 5'($urandom_range(0, 31));
      r = int'($urandom_range(0, 9));
      o.wait_n = (r < 7) ? (r % 4) : (r == 7) ? TO - 1 : (r == 8) ? TO : 50;
      r = int'($urandom_range(0, 9));
      o.flush_mode = (r == 0) ? 1 : (r == 1) ? 2 : 0;
      run_op(o);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
